// File: rtl/clock_12_24_pkg.sv
// Shared constants and the BCD split helper for the clock_12_24 time-of-day core.
// The build macro CLOCK_EDIT_RUN_EN (see clock_12_24.sv) needs nothing from this package.
package clock_12_24_pkg;

    localparam logic [1:0] FLD_HR  = 2'd0;
    localparam logic [1:0] FLD_MIN = 2'd1;
    localparam logic [1:0] FLD_SEC = 2'd2;

    localparam logic [4:0] HR_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    localparam int DIGIT_W = 6;

    // Splits a 0-59 value into {tens, ones}, each digit zero-extended to DIGIT_W bits.
    function automatic logic [2*DIGIT_W-1:0] to_bcd(input logic [5:0] bin);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = bin / 6'd10;
        ones = bin % 6'd10;
        return {tens, ones};
    endfunction

endpackage

// File: rtl/clock_12_24_tick.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 and pulses sec_tick for one cycle at the wrap.
module clock_12_24_tick #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic sec_tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A clear wins over counting and swallows any tick due in the same cycle.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
        end
    end

    assign sec_tick = en && !clr && (count_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_12_24.sv
// Time-of-day clock with 12/24-hour display and button-driven editing.
// Define CLOCK_EDIT_RUN_EN to keep time advancing while in edit mode.
module clock_12_24
    import clock_12_24_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_sw,
    input  logic        bC,
    input  logic        bL,
    input  logic        bR,
    input  logic        bD,
    output logic        fmt,
    output logic        ampm,
    output logic        edit,
    output logic [1:0]  currDigit,
    output logic [35:0] outReg
);

    logic [4:0]  hr_q, hr_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic        edit_q, edit_d;
    logic [1:0]  digit_q, digit_d;
    logic        fmt_q;
    logic        ampm_q, ampm_d;
    logic [35:0] out_q, out_d;
    logic [4:0]  disp_hr;
    logic        sec_tick;
    logic        tick_en;
    logic        tick_clr;

`ifdef CLOCK_EDIT_RUN_EN
    assign tick_en = 1'b1;
`else
    assign tick_en = !edit_q;
`endif
    assign tick_clr = bC && !edit_q;

    clock_12_24_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clr     (tick_clr),
        .en      (tick_en),
        .sec_tick(sec_tick)
    );

    // Time advance first, so an edit decrement in the same cycle overrides its own field.
    always_comb begin
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        edit_d  = edit_q;
        digit_d = digit_q;

        if (sec_tick) begin
            if (sec_q == MS_MAX) begin
                sec_d = '0;
                if (min_q == MS_MAX) begin
                    min_d = '0;
                    hr_d  = (hr_q == HR_MAX) ? '0 : hr_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        if (bC) begin
            edit_d = !edit_q;
            if (!edit_q) begin
                digit_d = FLD_HR;
            end
        end else if (edit_q && bD) begin
            case (digit_q)
                FLD_HR:  hr_d  = (hr_q  == '0) ? HR_MAX : hr_q  - 1'b1;
                FLD_MIN: min_d = (min_q == '0) ? MS_MAX : min_q - 1'b1;
                FLD_SEC: sec_d = (sec_q == '0) ? MS_MAX : sec_q - 1'b1;
                default: ;
            endcase
        end else if (edit_q && bL) begin
            digit_d = (digit_q == FLD_HR) ? FLD_SEC : digit_q - 1'b1;
        end else if (edit_q && bR) begin
            digit_d = (digit_q == FLD_SEC) ? FLD_HR : digit_q + 1'b1;
        end
    end

    // Display is derived from the next-state time so it lands in the same cycle as the count.
    always_comb begin
        disp_hr = hr_d;
        if (!m_sw) begin
            if (hr_d == 5'd0) begin
                disp_hr = 5'd12;
            end else if (hr_d > 5'd12) begin
                disp_hr = hr_d - 5'd12;
            end
        end
        ampm_d = !m_sw && (hr_d >= 5'd12);
        out_d  = {to_bcd({1'b0, disp_hr}), to_bcd(min_d), to_bcd(sec_d)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            edit_q  <= 1'b0;
            digit_q <= FLD_HR;
            fmt_q   <= m_sw;
            ampm_q  <= 1'b0;
            out_q   <= m_sw ? 36'd0 : {to_bcd(6'd12), 24'd0};
        end else begin
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            edit_q  <= edit_d;
            digit_q <= digit_d;
            fmt_q   <= m_sw;
            ampm_q  <= ampm_d;
            out_q   <= out_d;
        end
    end

    assign fmt       = fmt_q;
    assign ampm      = ampm_q;
    assign edit      = edit_q;
    assign currDigit = digit_q;
    assign outReg    = out_q;

endmodule

// File: tb/tb_clock_12_24.sv
// Scoreboard bench for clock_12_24 with TICKS_PER_SEC=4: directed stimulus queues hand-computed expectations.
module tb_clock_12_24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_sw = 1'b1;
    logic        bC = 1'b0;
    logic        bL = 1'b0;
    logic        bR = 1'b0;
    logic        bD = 1'b0;
    logic        fmt;
    logic        ampm;
    logic        edit;
    logic [1:0]  currDigit;
    logic [35:0] outReg;

    typedef struct {
        string       name;
        logic [35:0] out;
        logic        ampm;
        logic        edit;
        logic [1:0]  digit;
        logic        fmt;
    } exp_t;

    exp_t sb_q[$];
    int   compared = 0;
    int   mismatched = 0;

    clock_12_24 #(
        .TICKS_PER_SEC(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_sw     (m_sw),
        .bC       (bC),
        .bL       (bL),
        .bR       (bR),
        .bD       (bD),
        .fmt      (fmt),
        .ampm     (ampm),
        .edit     (edit),
        .currDigit(currDigit),
        .outReg   (outReg)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] expTime(input int h, input int m, input int s);
        return {6'(h / 10), 6'(h % 10), 6'(m / 10), 6'(m % 10), 6'(s / 10), 6'(s % 10)};
    endfunction

    // Monitor: outputs are stable at the falling edge, so every queued expectation is checked there.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compared++;
            if (outReg !== e.out || ampm !== e.ampm || edit !== e.edit ||
                currDigit !== e.digit || fmt !== e.fmt) begin
                mismatched++;
                $display("[TB] FAIL %s: got outReg=%h ampm=%b edit=%b currDigit=%0d fmt=%b, expected outReg=%h ampm=%b edit=%b currDigit=%0d fmt=%b",
                         e.name, outReg, ampm, edit, currDigit, fmt,
                         e.out, e.ampm, e.edit, e.digit, e.fmt);
            end
        end
    end

    task automatic checkOutput(input string name, input int h, input int m, input int s,
                               input logic ap, input logic ed, input logic [1:0] dg,
                               input logic fm);
        exp_t e;
        e.name  = name;
        e.out   = expTime(h, m, s);
        e.ampm  = ap;
        e.edit  = ed;
        e.digit = dg;
        e.fmt   = fm;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic c, input logic l, input logic r, input logic d);
        bC = c;
        bL = l;
        bR = r;
        bD = d;
        @(posedge clk);
        #1;
        bC = 1'b0;
        bL = 1'b0;
        bR = 1'b0;
        bD = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic sw);
        m_sw  = sw;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle(2);

        // Reset state in both formats, then free-running count
        doReset(1'b0);
        checkOutput("reset_12h", 12, 0, 0, 1'b0, 1'b0, 2'd0, 1'b0);
        doReset(1'b1);
        checkOutput("reset_24h", 0, 0, 0, 1'b0, 1'b0, 2'd0, 1'b1);
        idle(243);
        checkOutput("run_243", 0, 1, 0, 1'b0, 1'b0, 2'd0, 1'b1);
        idle(1);
        checkOutput("run_244", 0, 1, 1, 1'b0, 1'b0, 2'd0, 1'b1);

        // Preset 23:59:59 and roll over midnight
        doReset(1'b1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("preset_235959", 23, 59, 59, 1'b0, 1'b0, 2'd2, 1'b1);
        idle(3);
        checkOutput("pre_rollover", 23, 59, 59, 1'b0, 1'b0, 2'd2, 1'b1);
        idle(1);
        checkOutput("rollover", 0, 0, 0, 1'b0, 1'b0, 2'd2, 1'b1);
        m_sw = 1'b0;
        idle(1);
        checkOutput("midnight_12h", 12, 0, 0, 1'b0, 1'b0, 2'd2, 1'b0);

        // 13:05 in both formats; format switch must not disturb the count
        doReset(1'b1);
        applyStimulus(1, 0, 0, 0);
        repeat (11) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        repeat (55) applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("preset_1305_24h", 13, 5, 0, 1'b0, 1'b0, 2'd1, 1'b1);
        m_sw = 1'b0;
        idle(1);
        checkOutput("pm_12h", 1, 5, 0, 1'b1, 1'b0, 2'd1, 1'b0);
        m_sw = 1'b1;
        idle(1);
        checkOutput("back_24h", 13, 5, 0, 1'b0, 1'b0, 2'd1, 1'b1);
        idle(2);
        checkOutput("count_kept", 13, 5, 1, 1'b0, 1'b0, 2'd1, 1'b1);
        m_sw = 1'b0;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("noon_12h", 12, 5, 1, 1'b1, 1'b1, 2'd0, 1'b0);

        // Edit wraps, field selection and freeze
        doReset(1'b1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("enter_edit", 0, 0, 0, 1'b0, 1'b1, 2'd0, 1'b1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("hr_wrap", 23, 0, 0, 1'b0, 1'b1, 2'd0, 1'b1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("sel_right", 23, 0, 0, 1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("min_wrap", 23, 59, 0, 1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("sel_left1", 23, 59, 0, 1'b0, 1'b1, 2'd0, 1'b1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("sel_left2", 23, 59, 0, 1'b0, 1'b1, 2'd2, 1'b1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("sec_wrap", 23, 59, 59, 1'b0, 1'b1, 2'd2, 1'b1);
        idle(100);
        checkOutput("frozen", 23, 59, 59, 1'b0, 1'b1, 2'd2, 1'b1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("right_wrap", 23, 59, 59, 1'b0, 1'b1, 2'd0, 1'b1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("left_over_right", 23, 59, 59, 1'b0, 1'b1, 2'd2, 1'b1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("dec_over_right", 23, 59, 58, 1'b0, 1'b1, 2'd2, 1'b1);

        // Priority of bC, and buttons ignored outside edit
        applyStimulus(1, 0, 0, 1);
        checkOutput("toggle_only", 23, 59, 58, 1'b0, 1'b0, 2'd2, 1'b1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("dec_ignored", 23, 59, 58, 1'b0, 1'b0, 2'd2, 1'b1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("left_ignored", 23, 59, 58, 1'b0, 1'b0, 2'd2, 1'b1);

        // Reset in the middle of an edit
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("mid_edit", 23, 59, 58, 1'b0, 1'b1, 2'd1, 1'b1);
        doReset(1'b1);
        checkOutput("reset_mid_edit", 0, 0, 0, 1'b0, 1'b0, 2'd0, 1'b1);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
